// File: rtl/xbar_pipe.sv
// rtl/xbar_pipe.sv - registered NUM_PORTS x NUM_PORTS router crossbar with valid/ready outputs
//
// Moves flits from per-source inputs to per-output registers. The switch
// allocator supplies the routing as a select matrix. Several select bits set
// in one source row means multicast. Each output has a valid/ready register,
// which adds one pipeline stage and propagates backpressure upstream.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   sel           select matrix, bit [s*NUM_PORTS+d] routes source s to output d
//   in_valid      per-source flit valid
//   in_data       per-source flit, source s at [s*LINK_WIDTH +: LINK_WIDTH]
//   in_ready      per-source accept (combinational)
//   out_valid     per-output flit valid (registered)
//   out_data      per-output flit (registered), packed like in_data
//   out_ready     per-output downstream accept
//   conflict_clr  synchronous clear of conflict_err
//   conflict_err  sticky: two or more valid sources requested one output in a cycle

module xbar_pipe #(
  parameter int NUM_PORTS   = 5,
  parameter int LINK_WIDTH  = 32,
  parameter bit ALLOW_UTURN = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*NUM_PORTS-1:0]  sel,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [NUM_PORTS*LINK_WIDTH-1:0] in_data,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [NUM_PORTS-1:0]            out_valid,
  output logic [NUM_PORTS*LINK_WIDTH-1:0] out_data,
  input  logic [NUM_PORTS-1:0]            out_ready,
  input  logic                            conflict_clr,
  output logic                            conflict_err
);

  localparam int NP = NUM_PORTS;
  localparam int W  = LINK_WIDTH;

  generate
    if (NUM_PORTS < 2 || LINK_WIDTH < 1) begin : g_bad_params
      $error("xbar_pipe: NUM_PORTS must be >= 2 and LINK_WIDTH >= 1");
    end
  endgenerate

  logic [NP*NP-1:0] esel;
  logic [NP*NP-1:0] req;
  logic [NP-1:0]    can_load;
  logic [NP-1:0]    taken;
  logic             any_sel;
  logic             all_ok;
  logic             conflict;
  logic [NP-1:0]    fire;
  logic [NP-1:0]    load;
  logic [NP*W-1:0]  load_data;

  // U-turn bits are masked before anything else looks at the select matrix.
  always_comb begin
    esel = '0;
    for (int s = 0; s < NP; s++) begin
      for (int d = 0; d < NP; d++) begin
        esel[s*NP+d] = sel[s*NP+d] & (ALLOW_UTURN | (s != d));
      end
    end
  end

  always_comb begin
    req = '0;
    for (int s = 0; s < NP; s++) begin
      req[s*NP +: NP] = esel[s*NP +: NP] & {NP{in_valid[s]}};
    end
  end

  assign can_load = ~out_valid | out_ready;

  // Fixed-priority arbitration as a prefix scan in source order. taken[d]
  // says that a lower-index source already requests output d. So source s
  // owns d exactly when taken[d] is still clear on reaching s. The scan
  // tests source s against taken before adding its own requests. This
  // keeps in_ready[s] independent of in_valid[s]. A request that meets a
  // set taken bit is a second requester for that output, which is a conflict.
  always_comb begin
    taken    = '0;
    in_ready = '0;
    conflict = 1'b0;
    any_sel  = 1'b0;
    all_ok   = 1'b1;
    for (int s = 0; s < NP; s++) begin
      any_sel = 1'b0;
      all_ok  = 1'b1;
      for (int d = 0; d < NP; d++) begin
        if (esel[s*NP+d]) begin
          any_sel = 1'b1;
          if (taken[d] || !can_load[d]) all_ok = 1'b0;
        end
        if (req[s*NP+d] && taken[d]) conflict = 1'b1;
      end
      // Multicast is all-or-nothing: every selected output must be owned and free.
      in_ready[s] = any_sel & all_ok;
      taken       = taken | req[s*NP +: NP];
    end
  end

  assign fire = in_valid & in_ready;

  // A firing source owns all of its outputs, so at most one source loads each output.
  always_comb begin
    load      = '0;
    load_data = '0;
    for (int d = 0; d < NP; d++) begin
      for (int s = 0; s < NP; s++) begin
        if (fire[s] && esel[s*NP+d]) begin
          load[d]              = 1'b1;
          load_data[d*W +: W]  = in_data[s*W +: W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= '0;
      out_data     <= '0;
      conflict_err <= 1'b0;
    end else begin
      for (int d = 0; d < NP; d++) begin
        if (load[d]) begin
          out_data[d*W +: W] <= load_data[d*W +: W];
          out_valid[d]       <= 1'b1;
        end else if (out_ready[d]) begin
          out_valid[d] <= 1'b0;
        end
      end
      if (conflict) begin
        conflict_err <= 1'b1;
      end else if (conflict_clr) begin
        conflict_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xbar_pipe.sv
// tb/tb_xbar_pipe.sv - self-checking bench for xbar_pipe, U-turn masked and U-turn allowed instances
module tb_xbar_pipe;
  localparam int NP = 5;
  localparam int W  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP*NP-1:0]  sel = '0;
  logic [NP-1:0]     in_valid = '0;
  logic [NP*W-1:0]   in_data = '0;
  logic [NP-1:0]     out_ready = '0;
  logic              conflict_clr = 1'b0;

  logic [NP-1:0]     in_ready0, in_ready1, out_valid0, out_valid1;
  logic [NP*W-1:0]   out_data0, out_data1;
  logic              err0, err1;

  xbar_pipe #(.NUM_PORTS(NP), .LINK_WIDTH(W), .ALLOW_UTURN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
    .out_ready(out_ready), .conflict_clr(conflict_clr), .conflict_err(err0));

  xbar_pipe #(.NUM_PORTS(NP), .LINK_WIDTH(W), .ALLOW_UTURN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .out_ready(out_ready), .conflict_clr(conflict_clr), .conflict_err(err1));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state per instance (index = ALLOW_UTURN value).
  logic [NP-1:0] m_valid [2];
  logic [W-1:0]  m_data  [2][NP];
  logic          m_err   [2];
  logic [NP-1:0] m_rdy   [2];
  logic [NP-1:0] n_valid [2];
  logic [W-1:0]  n_data  [2][NP];
  logic          n_err   [2];
  logic [NP-1:0] last_rdy0, last_rdy1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit es(input int a, input int s, input int d);
    return sel[s*NP+d] && (a != 0 || s != d);
  endfunction

  // Winner of output d is the smallest requesting source. Source s is ready
  // when it selects something, no smaller source requests any of its targets,
  // and every target is empty or draining.
  task automatic model_eval(input int k);
    int  win [NP];
    int  cnt;
    bit  conf;
    bit  any, ok, loaded;
    conf = 0;
    for (int d = 0; d < NP; d++) begin
      win[d] = NP;
      cnt = 0;
      for (int s = 0; s < NP; s++) begin
        if (in_valid[s] && es(k, s, d)) begin
          cnt++;
          if (s < win[d]) win[d] = s;
        end
      end
      if (cnt > 1) conf = 1;
    end
    for (int s = 0; s < NP; s++) begin
      any = 0; ok = 1;
      for (int d = 0; d < NP; d++) begin
        if (es(k, s, d)) begin
          any = 1;
          if (win[d] < s) ok = 0;
          if (m_valid[k][d] && !out_ready[d]) ok = 0;
        end
      end
      m_rdy[k][s] = any && ok;
    end
    n_valid[k] = m_valid[k];
    for (int d = 0; d < NP; d++) begin
      n_data[k][d] = m_data[k][d];
      loaded = 0;
      for (int s = 0; s < NP; s++) begin
        if (in_valid[s] && m_rdy[k][s] && es(k, s, d)) begin
          n_data[k][d] = in_data[s*W +: W];
          loaded = 1;
        end
      end
      if (loaded) n_valid[k][d] = 1'b1;
      else if (out_ready[d]) n_valid[k][d] = 1'b0;
    end
    n_err[k] = conf ? 1'b1 : (conflict_clr ? 1'b0 : m_err[k]);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = '0;
      m_err[k] = 1'b0;
      for (int d = 0; d < NP; d++) m_data[k][d] = '0;
    end
  endtask

  function automatic logic [W-1:0] od(input int k, input int d);
    return (k == 0) ? out_data0[d*W +: W] : out_data1[d*W +: W];
  endfunction

  // One cycle: check combinational ready at negedge, clock, check registers.
  task automatic step();
    @(negedge clk);
    model_eval(0);
    model_eval(1);
    last_rdy0 = in_ready0;
    last_rdy1 = in_ready1;
    check("in_ready u0", in_ready0, m_rdy[0]);
    check("in_ready u1", in_ready1, m_rdy[1]);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = n_valid[k];
      m_err[k] = n_err[k];
      for (int d = 0; d < NP; d++) m_data[k][d] = n_data[k][d];
    end
    check("out_valid u0", out_valid0, m_valid[0]);
    check("out_valid u1", out_valid1, m_valid[1]);
    check("conflict_err u0", err0, m_err[0]);
    check("conflict_err u1", err1, m_err[1]);
    for (int d = 0; d < NP; d++) begin
      if (m_valid[0][d]) check($sformatf("out_data u0 p%0d", d), od(0, d), m_data[0][d]);
      if (m_valid[1][d]) check($sformatf("out_data u1 p%0d", d), od(1, d), m_data[1][d]);
    end
  endtask

  function automatic logic [NP*NP-1:0] route(input int s, input int d);
    logic [NP*NP-1:0] v;
    v = '0;
    v[s*NP+d] = 1'b1;
    return v;
  endfunction

  logic [W-1:0] held;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", out_valid0, '0);
    check("reset out_data", out_data0, '0);
    check("reset err", err0, '0);
    rst_n = 1'b1;

    // Unicast permutation.
    sel = route(0,3) | route(1,4) | route(2,0) | route(3,1) | route(4,2);
    for (int s = 0; s < NP; s++) in_data[s*W +: W] = 32'hA0 + s;
    in_valid = '1;
    out_ready = '1;
    step();
    check("uni in_ready", last_rdy0, 5'h1F);
    check("uni out3", od(0,3), 32'hA0);
    check("uni out4", od(0,4), 32'hA1);
    check("uni out0", od(0,0), 32'hA2);
    check("uni out1", od(0,1), 32'hA3);
    check("uni out2", od(0,2), 32'hA4);

    // Conflict on output 2: source 1 beats source 3.
    sel = route(1,2) | route(3,2);
    in_data[1*W +: W] = 32'hB1;
    in_data[3*W +: W] = 32'hB3;
    in_valid = 5'b01010;
    step();
    check("conf rdy3", last_rdy0[3], 1'b0);
    check("conf out2", od(0,2), 32'hB1);
    check("conf err", err0, 1'b1);
    in_valid = 5'b01000;
    conflict_clr = 1'b1;
    step();
    conflict_clr = 1'b0;
    check("clr err", err0, 1'b0);
    check("clr out2", od(0,2), 32'hB3);

    // Backpressure on output 2.
    in_data[3*W +: W] = 32'hC3;
    out_ready = 5'b11011;
    held = od(0,2);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp hold", od(0,2), held);
      check("bp rdy3", last_rdy0[3], 1'b0);
    end
    out_ready = '1;
    step();
    check("bp release", od(0,2), 32'hC3);
    check("bp valid", out_valid0[2], 1'b1);

    // Multicast blocked by a stalled output, then released.
    sel = route(4,3);
    in_valid = 5'b10000;
    in_data[4*W +: W] = 32'hD4;
    out_ready = 5'b10111;
    step();
    sel = route(0,1) | route(0,3);
    in_valid = 5'b00001;
    in_data[0*W +: W] = 32'hE0;
    step();
    check("mc rdy0", last_rdy0[0], 1'b0);
    check("mc out1 idle", out_valid0[1], 1'b0);
    check("mc out3 hold", od(0,3), 32'hD4);
    out_ready = '1;
    step();
    check("mc out1", od(0,1), 32'hE0);
    check("mc out3", od(0,3), 32'hE0);
    check("mc valid", out_valid0 & 5'b01010, 5'b01010);

    // U-turn: masked in dut0, delivered in dut1.
    sel = route(2,2);
    in_valid = 5'b00100;
    in_data[2*W +: W] = 32'hF2;
    step();
    check("ut rdy u0", last_rdy0[2], 1'b0);
    check("ut rdy u1", last_rdy1[2], 1'b1);
    check("ut err u0", err0, 1'b0);
    check("ut valid u0", out_valid0[2], 1'b0);
    check("ut out u1", od(1,2), 32'hF2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      sel = '0;
      for (int s = 0; s < NP; s++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) sel |= route(s, $urandom_range(0, NP-1));
        else if (r < 8) sel |= route(s, $urandom_range(0, NP-1)) | route(s, $urandom_range(0, NP-1));
      end
      in_valid = NP'($urandom);
      out_ready = NP'($urandom) | NP'($urandom);
      for (int s = 0; s < NP; s++) in_data[s*W +: W] = $urandom;
      conflict_clr = ($urandom_range(0, 7) == 0);
      step();
    end
    conflict_clr = 1'b0;

    // Asynchronous reset mid-traffic with out_valid = 5'b10110.
    in_valid = '0;
    out_ready = '1;
    step();
    sel = route(0,1) | route(1,2) | route(3,4) | route(2,4);
    in_valid = 5'b01111;
    out_ready = '0;
    step();
    check("pre-reset valid", out_valid0, 5'b10110);
    check("pre-reset err", err0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst valid", out_valid0, '0);
    check("async rst data", out_data0, '0);
    check("async rst err", err0, 1'b0);
    check("async rst valid u1", out_valid1, '0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = '0;
    out_ready = '1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
